// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready result handshake.
// Optional MULDIV_EARLY_OUT_EN: trivial operand cases finish one cycle after accept.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]        f3;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic            accept;
  logic            a_sgn;
  logic            b_sgn;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            early_hit;
  logic [XLEN-1:0] early_res;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;

  assign a_sgn = op_a[XLEN-1] &
                 (funct3[2] ? ~funct3[0]
                            : (funct3[1:0] == 2'b01 ||
                               funct3[1:0] == 2'b10));
  assign b_sgn = op_b[XLEN-1] &
                 (funct3[2] ? ~funct3[0]
                            : (funct3[1:0] == 2'b01));
  assign a_abs = a_sgn ? -op_a : op_a;
  assign b_abs = b_sgn ? -op_b : op_b;

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (funct3[2]) begin
      if (op_b == '0) begin
        early_hit = 1'b1;
        early_res = funct3[1] ? op_a : '1;
      end else if (!funct3[0] && op_a == SMIN && op_b == '1) begin
        early_hit = 1'b1;
        early_res = funct3[1] ? '0 : SMIN;
      end else if (op_a == '0) begin
        early_hit = 1'b1;
      end
    end else if (op_a == '0 || op_b == '0) begin
      early_hit = 1'b1;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  // acc holds {hi, lo} of the product, or {remainder, quotient} when dividing
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_nx;

  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_mag};
  assign mul_nx  = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                          : {1'b0, acc[2*XLEN-1:1]};

  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, b_mag};
  assign div_nx    = div_trial[XLEN]
                   ? {acc[2*XLEN-2:0], 1'b0}
                   : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic              q_neg;
  logic              b_zero;
  logic [XLEN-1:0]   fix_res;

  assign q_neg  = sign_a ^ sign_b;
  assign prod   = q_neg ? -acc : acc;
  assign quo    = acc[XLEN-1:0];
  assign rem    = acc[2*XLEN-1:XLEN];
  assign b_zero = (b_mag == '0);

  // x/0 leaves rem = |op_a|, so restoring its sign gives op_a back
  always_comb begin
    fix_res = '0;
    unique case (f3)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = b_zero ? '1
                                      : (q_neg ? -quo : quo);
      default:                fix_res = sign_a ? -rem : rem;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = early_hit ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush && state != IDLE) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      f3     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_mag  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (accept) begin
          f3     <= funct3;
          sign_a <= a_sgn;
          sign_b <= b_sgn;
          b_mag  <= b_abs;
          acc    <= {{XLEN{1'b0}}, a_abs};
          cnt    <= CNT_W'(XLEN);
          if (early_hit) result <= early_res;
        end
        CALC: begin
          acc <= f3[2] ? div_nx : mul_nx;
          cnt <= cnt - CNT_W'(1);
        end
        FIX:  result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit, checked against an arithmetic model.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a,
                                            logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(logic [2:0] f, logic [31:0] a,
                                     logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    bit ovf;
    ovf = !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    if (f[2] && (b == 0 || ovf || a == 0)) return 1;
    if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
    return XLEN + 2;
  endfunction

  int lat;
  int ready_hi;

  task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    funct3 = f; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    ready_hi = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_hi++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(string tag, logic [2:0] f, logic [31:0] a,
                        logic [31:0] b);
    issue(f, a, b);
    chk({tag, "_res"}, result, ref_model(f, a, b));
    chk({tag, "_lat"}, lat, exp_latency(f, a, b));
    chk({tag, "_rdy"}, ready_hi, 0);
    consume();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    int vhi;
    rst = 1'b1; in_valid = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    run_op("mul_7x-3", 3'd0, 32'h7, 32'hFFFF_FFFD);
    chk("mul_7x-3_abs", result, 32'hFFFF_FFEB);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000);
    run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'h2);
    run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'h2);
    run_op("divu", 3'd5, 32'hFFFF_FFF9, 32'h2);
    run_op("remu", 3'd7, 32'hFFFF_FFF9, 32'h2);
    run_op("div_by0", 3'd4, 32'hFFFF_FFF9, 32'h0);
    run_op("rem_by0", 3'd6, 32'hFFFF_FFF9, 32'h0);
    run_op("divu_by0", 3'd5, 32'h1234_5678, 32'h0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    issue(3'd0, 32'h1234, 32'h5678);
    chk("hold_res", result, ref_model(3'd0, 32'h1234, 32'h5678));
    held = result;
    funct3 = 3'd5; op_a = 32'h9; op_b = 32'h3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_stable_%0d", i), result, held);
      chk($sformatf("hold_valid_%0d", i), out_valid, 1);
      chk($sformatf("hold_noacc_%0d", i), in_ready, 0);
    end
    in_valid = 1'b0;
    consume();
    chk("post_consume_idle", in_ready, 1);

    issue(3'd0, 32'h0, 32'h0);
    chk("mul_zero", result, 0);
    chk("mul_zero_lat", lat, exp_latency(3'd0, 32'h0, 32'h0));
    consume();

    funct3 = 3'd0; op_a = 32'h3; op_b = 32'h5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    vhi = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) vhi++;
    end
    chk("flush_never_valid", vhi, 0);

    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_noacc", busy, 0);

    funct3 = 3'd4; op_a = 32'h64; op_b = 32'h7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("midcalc_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), f, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
